// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the Y86-64 SEQ stage controller.
//   - icode constants (I_HALT..I_POPQ)
//   - stat codes (S_AOK, S_HLT, S_ADR, S_INS)
//   - controller state enum (StPause only exists when SINGLE_STEP_EN is defined)
//   - instr_legal(): icode/ifun legality check done in DECODE
//   - uses_mem(): icodes that issue a data memory request in MEM
package seq_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StPcupd,
`ifdef SINGLE_STEP_EN
        StPause,
`endif
        StStop
    } state_e;

    function automatic logic instr_legal(input logic [3:0] ic, input logic [3:0] fn);
        logic ok;
        case (ic)
            I_RRMOVQ, I_JXX: ok = (fn <= 4'd6);
            I_OPQ:           ok = (fn <= 4'd3);
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ: ok = (fn == 4'd0);
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic uses_mem(input logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
               (ic == I_RET) || (ic == I_PUSHQ) || (ic == I_POPQ);
    endfunction

endpackage

// File: rtl/seq_next_pc.sv
// seq_next_pc: combinational new-PC select for the PC-update stage.
// Ports:
//   icode  in   instruction code
//   cnd    in   branch condition from execute
//   valC   in   constant word (call / taken jump target)
//   valM   in   word read from memory (ret target)
//   valP   in   sequential next PC
//   new_pc out  selected next PC
module seq_next_pc
    import seq_pkg::*;
#(
    parameter int unsigned PC_W = 64
) (
    input  logic [3:0]      icode,
    input  logic            cnd,
    input  logic [PC_W-1:0] valC,
    input  logic [PC_W-1:0] valM,
    input  logic [PC_W-1:0] valP,
    output logic [PC_W-1:0] new_pc
);

    always_comb begin
        new_pc = valP;
        if (icode == I_CALL || (icode == I_JXX && cnd)) begin
            new_pc = valC;
        end else if (icode == I_RET) begin
            new_pc = valM;
        end
    end

endmodule

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: multi-cycle sequencer for the Y86-64 SEQ datapath.
// Owns the architectural PC, walks FETCH..PCUPD one stage per state, raises the
// per-stage enables and tracks Y86 status.
// Optional feature macro: SINGLE_STEP_EN (adds input step and a PAUSE state
// after every PC update; PAUSE advances to FETCH when step=1).
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  leave IDLE and begin at the current PC
//   step                   (SINGLE_STEP_EN only) release PAUSE
//   icode, ifun, valP, valC from fetch
//   valM                   from memory stage
//   cnd                    condition from execute
//   mem_ack, dmem_err      data memory handshake
//   PC                     current instruction address
//   fetch_en..pc_en        stage enables, one-hot together with mem_req
//   mem_req                data memory request
//   stat                   1=AOK 2=HLT 3=ADR 4=INS
//   busy                   high outside IDLE and STOP
//   cycle_cnt, instr_cnt   saturating cycle / retired-instruction counters
module seq_stage_controller
    import seq_pkg::*;
#(
    parameter int unsigned     PC_W        = 64,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     IMEM_BYTES  = 1024,
    parameter int unsigned     MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [3:0]      icode,
    input  logic [3:0]      ifun,
    input  logic [PC_W-1:0] valP,
    input  logic [PC_W-1:0] valC,
    input  logic [PC_W-1:0] valM,
    input  logic            cnd,
    input  logic            mem_ack,
    input  logic            dmem_err,
    output logic [PC_W-1:0] PC,
    output logic            fetch_en,
    output logic            decode_en,
    output logic            exec_en,
    output logic            wb_en,
    output logic            pc_en,
    output logic            mem_req,
    output logic [2:0]      stat,
    output logic            busy,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     instr_cnt
);

    localparam int unsigned     CntW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] MemLast   = CntW'(MEM_TIMEOUT - 1);
    localparam logic [PC_W-1:0] ImemLimit = PC_W'(IMEM_BYTES);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      stat_q, stat_d;
    logic [CntW-1:0] mem_cnt_q, mem_cnt_d;
    logic [31:0]     cycle_q, instr_q;
    logic [PC_W-1:0] new_pc;
    logic            in_pipe;

    seq_next_pc #(
        .PC_W (PC_W)
    ) u_next_pc (
        .icode  (icode),
        .cnd    (cnd),
        .valC   (valC),
        .valM   (valM),
        .valP   (valP),
        .new_pc (new_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stat_d    = stat_q;
        mem_cnt_d = '0;
        unique case (state_q)
            StIdle:   if (start) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                // Faults leave PC on the offending instruction.
                if (!instr_legal(icode, ifun)) begin
                    stat_d  = S_INS;
                    state_d = StStop;
                end else if (valP > ImemLimit) begin
                    stat_d  = S_ADR;
                    state_d = StStop;
                end else if (icode == I_HALT) begin
                    stat_d  = S_HLT;
                    state_d = StStop;
                end else begin
                    state_d = StExec;
                end
            end
            StExec:   state_d = StMem;
            StMem: begin
                if (!uses_mem(icode)) begin
                    state_d = StWb;
                end else if (dmem_err) begin
                    stat_d  = S_ADR;
                    state_d = StStop;
                end else if (mem_ack) begin
                    state_d = StWb;
                end else if (mem_cnt_q == MemLast) begin
                    stat_d  = S_ADR;
                    state_d = StStop;
                end else begin
                    mem_cnt_d = mem_cnt_q + 1'b1;
                end
            end
            StWb:     state_d = StPcupd;
            StPcupd: begin
                pc_d = new_pc;
`ifdef SINGLE_STEP_EN
                state_d = StPause;
`else
                state_d = StFetch;
`endif
            end
`ifdef SINGLE_STEP_EN
            StPause:  if (step) state_d = StFetch;
`endif
            StStop:   state_d = StStop;
            default:  state_d = StIdle;
        endcase
    end

    assign in_pipe = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec) ||
                     (state_q == StMem) || (state_q == StWb) || (state_q == StPcupd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            stat_q    <= S_AOK;
            mem_cnt_q <= '0;
            cycle_q   <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stat_q    <= stat_d;
            mem_cnt_q <= mem_cnt_d;
            if (in_pipe && cycle_q != 32'hFFFF_FFFF) cycle_q <= cycle_q + 32'd1;
            if (state_q == StPcupd && instr_q != 32'hFFFF_FFFF) instr_q <= instr_q + 32'd1;
        end
    end

    assign PC        = pc_q;
    assign stat      = stat_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
    assign fetch_en  = (state_q == StFetch);
    assign decode_en = (state_q == StDecode);
    assign exec_en   = (state_q == StExec);
    assign wb_en     = (state_q == StWb);
    assign pc_en     = (state_q == StPcupd);
    assign mem_req   = (state_q == StMem) && uses_mem(icode);
    assign busy      = (state_q != StIdle) && (state_q != StStop);

endmodule

// File: tb/tb_seq_stage_controller.sv
// tb_seq_stage_controller: directed bench for seq_stage_controller (default build).
// A per-instruction model expands each instruction into its expected cycle
// trace (stage, mem_req, PC, stat, counters); a compare process checks the DUT
// against that trace on every falling edge. Literal checks pin the model.
module tb_seq_stage_controller;

    localparam int unsigned PC_W = 64;

    logic            clk = 1'b0;
    logic            rst_n, start, cnd, mem_ack, dmem_err;
    logic [3:0]      icode, ifun;
    logic [PC_W-1:0] valP, valC, valM, PC;
    logic            fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, busy;
    logic [2:0]      stat;
    logic [31:0]     cycle_cnt, instr_cnt;

    always #5 clk = ~clk;

    seq_stage_controller #(
        .PC_W        (PC_W),
        .RESET_PC    ('0),
        .IMEM_BYTES  (1024),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .icode     (icode),
        .ifun      (ifun),
        .valP      (valP),
        .valC      (valC),
        .valM      (valM),
        .cnd       (cnd),
        .mem_ack   (mem_ack),
        .dmem_err  (dmem_err),
        .PC        (PC),
        .fetch_en  (fetch_en),
        .decode_en (decode_en),
        .exec_en   (exec_en),
        .wb_en     (wb_en),
        .pc_en     (pc_en),
        .mem_req   (mem_req),
        .stat      (stat),
        .busy      (busy),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Stage codes: 0 idle/stop, 1 F, 2 D, 3 E, 4 M, 5 W, 6 P.
    typedef struct {
        int          stage;
        bit          mreq;
        logic [2:0]  stat;
        logic [63:0] pc;
        int unsigned icnt;
        int unsigned ccnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [5:0]  en_exp;
    logic [63:0] m_pc;
    logic [2:0]  m_stat;
    int unsigned m_icnt, m_cyc;
    int          max_ifun[12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};
    string       stage_name[7] = '{"idle", "F", "D", "E", "M", "W", "P"};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc   = '0;
        m_stat = 3'd1;
        m_icnt = 0;
        m_cyc  = 0;
    endtask

    // Queue what the DUT must show during the current cycle.
    task automatic expect_cycle(input int stage, input bit mreq);
        exp_t e;
        e.stage = stage;
        e.mreq  = mreq;
        e.stat  = m_stat;
        e.pc    = m_pc;
        e.icnt  = m_icnt;
        e.ccnt  = m_cyc;
        exp_q.push_back(e);
        if (stage != 0) m_cyc++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            case (cur.stage)
                1:       en_exp = 6'b100000;
                2:       en_exp = 6'b010000;
                3:       en_exp = 6'b001000;
                4:       en_exp = cur.mreq ? 6'b000100 : 6'b000000;
                5:       en_exp = 6'b000010;
                6:       en_exp = 6'b000001;
                default: en_exp = 6'b000000;
            endcase
            check({"enables@", stage_name[cur.stage]},
                  64'({fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en}), 64'(en_exp));
            check({"busy@", stage_name[cur.stage]}, 64'(busy), 64'(cur.stage != 0));
            check({"stat@", stage_name[cur.stage]}, 64'(stat), 64'(cur.stat));
            check({"pc@", stage_name[cur.stage]}, PC, cur.pc);
            check({"instr_cnt@", stage_name[cur.stage]}, 64'(instr_cnt), 64'(cur.icnt));
            check({"cycle_cnt@", stage_name[cur.stage]}, 64'(cycle_cnt), 64'(cur.ccnt));
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        mem_ack  = 1'b0;
        dmem_err = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        expect_cycle(0, 1'b0);
        tick();
    endtask

    task automatic do_start();
        expect_cycle(0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // A few STOP cycles, one of them with start raised (must be ignored).
    task automatic stop_tail();
        expect_cycle(0, 1'b0);
        tick();
        expect_cycle(0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_cycle(0, 1'b0);
        tick();
    endtask

    // ack_at/err_at/rst_at: MEM cycle (1-based) on which that event happens, 0 = never.
    task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn,
                             input logic [63:0] vp, input logic [63:0] vc,
                             input logic [63:0] vm, input bit c,
                             input int ack_at, input int err_at, input int rst_at);
        logic [2:0] fault;
        bit         is_mem;
        icode = ic;
        ifun  = fn;
        valP  = vp;
        valC  = vc;
        valM  = vm;
        cnd   = c;
        expect_cycle(1, 1'b0);
        tick();
        expect_cycle(2, 1'b0);
        tick();
        fault = 3'd0;
        if (int'(ic) > 11)                fault = 3'd4;
        else if (int'(fn) > max_ifun[ic]) fault = 3'd4;
        else if (vp > 64'd1024)           fault = 3'd3;
        else if (ic == 4'h0)              fault = 3'd2;
        if (fault != 3'd0) begin
            m_stat = fault;
            stop_tail();
            return;
        end
        expect_cycle(3, 1'b0);
        tick();
        is_mem = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
                 (ic == 4'hA) || (ic == 4'hB);
        if (!is_mem) begin
            expect_cycle(4, 1'b0);
            tick();
        end else begin
            for (int k = 1; k <= 15; k++) begin
                expect_cycle(4, 1'b1);
                mem_ack  = (ack_at == k);
                dmem_err = (err_at == k);
                if (rst_at == k) rst_n = 1'b0;
                tick();
                mem_ack  = 1'b0;
                dmem_err = 1'b0;
                if (rst_at == k) begin
                    rst_n = 1'b1;
                    model_reset();
                    expect_cycle(0, 1'b0);
                    tick();
                    return;
                end
                if (err_at == k || (ack_at != k && k == 15)) begin
                    m_stat = 3'd3;
                    stop_tail();
                    return;
                end
                if (ack_at == k) break;
            end
        end
        expect_cycle(5, 1'b0);
        tick();
        expect_cycle(6, 1'b0);
        tick();
        if (ic == 4'h8 || (ic == 4'h7 && c)) m_pc = vc;
        else if (ic == 4'h9)                 m_pc = vm;
        else                                 m_pc = vp;
        m_icnt++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cnd = 1'b0; mem_ack = 1'b0; dmem_err = 1'b0;
        icode = 4'h1; ifun = 4'h0; valP = '0; valC = '0; valM = '0;

        do_reset();
        check("reset_pc", PC, 64'd0);
        check("reset_stat", 64'(stat), 64'd1);

        // Straight-line program ending in halt at PC 16.
        do_start();
        run_instr(4'h1, 4'h0, 64'd1, 64'd0, 64'd0, 1'b0, 0, 0, 0);
        check("nop_pc", PC, 64'd1);
        check("nop_instr_cnt", 64'(instr_cnt), 64'd1);
        check("nop_cycles", 64'(cycle_cnt), 64'd6);
        run_instr(4'h7, 4'h1, 64'd9, 64'd1024, 64'd0, 1'b1, 0, 0, 0);
        check("jxx_taken_pc", PC, 64'd1024);
        run_instr(4'h7, 4'h1, 64'd9, 64'd1024, 64'd0, 1'b0, 0, 0, 0);
        check("jxx_not_taken_pc", PC, 64'd9);
        run_instr(4'h8, 4'h0, 64'd18, 64'd204, 64'd0, 1'b0, 3, 0, 0);
        check("call_pc", PC, 64'd204);
        check("call_cycles", 64'(cycle_cnt), 64'd26);
        run_instr(4'h6, 4'h3, 64'd1024, 64'd0, 64'd0, 1'b0, 0, 0, 0);
        check("valp_at_limit_pc", PC, 64'd1024);
        run_instr(4'h2, 4'h6, 64'd40, 64'd0, 64'd0, 1'b0, 0, 0, 0);
        run_instr(4'h5, 4'h0, 64'd50, 64'd0, 64'd0, 1'b0, 15, 0, 0);
        check("ack_at_timeout_pc", PC, 64'd50);
        check("ack_at_timeout_stat", 64'(stat), 64'd1);
        run_instr(4'h9, 4'h0, 64'd51, 64'd0, 64'd16, 1'b0, 1, 0, 0);
        check("ret_pc", PC, 64'd16);
        run_instr(4'h0, 4'h0, 64'd17, 64'd0, 64'd0, 1'b0, 0, 0, 0);
        check("halt_stat", 64'(stat), 64'd2);
        check("halt_pc", PC, 64'd16);
        check("halt_busy", 64'(busy), 64'd0);
        check("halt_instr_cnt", 64'(instr_cnt), 64'd8);

        do_reset();
        do_start();
        run_instr(4'hC, 4'h0, 64'd1, 64'd0, 64'd0, 1'b0, 0, 0, 0);
        check("bad_icode_stat", 64'(stat), 64'd4);
        check("bad_icode_pc", PC, 64'd0);

        do_reset();
        do_start();
        run_instr(4'h1, 4'h1, 64'd1, 64'd0, 64'd0, 1'b0, 0, 0, 0);
        check("bad_ifun_stat", 64'(stat), 64'd4);

        do_reset();
        do_start();
        run_instr(4'h1, 4'h0, 64'd1025, 64'd0, 64'd0, 1'b0, 0, 0, 0);
        check("valp_over_limit_stat", 64'(stat), 64'd3);

        do_reset();
        do_start();
        run_instr(4'h5, 4'h0, 64'd10, 64'd0, 64'd0, 1'b0, 0, 0, 0);
        check("timeout_stat", 64'(stat), 64'd3);
        check("timeout_cycles", 64'(cycle_cnt), 64'd18);

        do_reset();
        do_start();
        run_instr(4'h5, 4'h0, 64'd10, 64'd0, 64'd0, 1'b0, 2, 2, 0);
        check("err_beats_ack_stat", 64'(stat), 64'd3);

        do_reset();
        do_start();
        run_instr(4'h1, 4'h0, 64'd5, 64'd0, 64'd0, 1'b0, 0, 0, 0);
        run_instr(4'hA, 4'h0, 64'd7, 64'd0, 64'd0, 1'b0, 0, 0, 2);
        check("mid_reset_pc", PC, 64'd0);
        check("mid_reset_stat", 64'(stat), 64'd1);
        check("mid_reset_instr_cnt", 64'(instr_cnt), 64'd0);
        check("mid_reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("mid_reset_mem_req", 64'(mem_req), 64'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
